// File: rtl/text_write_scheduler.sv
// -----------------------------------------------------------------------------
// text_write_scheduler
//
// Queues CPU character writes in a small FIFO and drains them into text_buffer
// one cell per cycle, but only while write_window is high (display blanking).
// Writes are drained in arrival order. Addresses outside the screen are
// acknowledged and dropped.
//
// Optional clear-screen engine, built only when the macro TEXT_CLEAR_EN is
// defined: a clr_req pulse flushes the queue and fills cells 0..CELLS-1 with
// BLANK_CHAR, again only while write_window is high. Without the macro,
// clr_req is ignored and clr_busy is tied low.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   cpu_req/addr/char     CPU write request (level), cell address, code
//   cpu_ack               combinational; the request is taken at this edge
//   clr_req, clr_busy     clear-screen request pulse / clear in progress
//   write_window          1 = text_buffer may be written this cycle
//   tb_we/waddr/char      registered write port toward text_buffer
//   fifo_count, fifo_full queue occupancy (0..FIFO_DEPTH) and full flag
// -----------------------------------------------------------------------------
module text_write_scheduler #(
  parameter int         FIFO_DEPTH = 8,
  parameter int         CELLS      = 2400,
  parameter logic [3:0] BLANK_CHAR = 4'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic [11:0] cpu_addr,
  input  logic [3:0]  cpu_char,
  output logic        cpu_ack,
  input  logic        clr_req,
  output logic        clr_busy,
  input  logic        write_window,
  output logic        tb_we,
  output logic [11:0] tb_waddr,
  output logic [3:0]  tb_char,
  output logic [3:0]  fifo_count,
  output logic        fifo_full
);

  localparam int          PTR_W     = $clog2(FIFO_DEPTH);
  localparam logic [3:0]  DEPTH_C   = 4'(FIFO_DEPTH);
  localparam logic [11:0] LAST_CELL = 12'(CELLS - 1);

`ifdef TEXT_CLEAR_EN
  typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_t;
`else
  typedef enum logic [1:0] {IDLE, DRAIN} state_t;
`endif

  typedef struct packed {
    logic [11:0] addr;
    logic [3:0]  chr;
  } entry_t;

  entry_t           mem [FIFO_DEPTH];
  entry_t           head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  state_t           state;
  logic             fifo_empty;
  logic             push;
  logic             pop;

  assign fifo_full  = (fifo_count == DEPTH_C);
  assign fifo_empty = (fifo_count == 4'd0);
  // Fullness is the registered pre-edge count, so a full queue never accepts.
  assign cpu_ack    = rst_n & cpu_req & ~fifo_full;
  // Off-screen addresses are acknowledged but never stored.
  assign push       = cpu_ack & (cpu_addr <= LAST_CELL);
  assign head       = mem[rd_ptr];

  // NOTE: the storage array has no reset; the pointers and count alone decide
  // which entries are valid, and leaving the array unreset lets it map to RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cpu_addr, cpu_char};
  end

`ifdef TEXT_CLEAR_EN
  logic [11:0] clr_cnt;
  logic        blank_write;

  // A clear request wins over any pop or blank write in the same cycle.
  // NOTE: every signal assigned here gets a default first, so no path through
  // the block can leave it unassigned and infer a latch.
  always_comb begin
    pop         = 1'b0;
    blank_write = 1'b0;
    if (!clr_req) begin
      if (state == CLEAR) blank_write = write_window;
      else                pop         = write_window & ~fifo_empty;
    end
  end
`else
  // clr_req and BLANK_CHAR only matter to the clear engine.
  logic [4:0] clear_cfg_unused;
  assign clear_cfg_unused = {clr_req, BLANK_CHAR};
  assign clr_busy         = 1'b0;
  assign pop              = write_window & ~fifo_empty;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every
  // right-hand side below reads the pre-edge value regardless of order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      tb_we      <= 1'b0;
      tb_waddr   <= '0;
      tb_char    <= '0;
`ifdef TEXT_CLEAR_EN
      clr_busy   <= 1'b0;
      clr_cnt    <= '0;
`endif
    end else begin
      // Output port: one-cycle write pulse, address/data held between writes.
`ifdef TEXT_CLEAR_EN
      tb_we <= pop | blank_write;
      if (blank_write) begin
        tb_waddr <= clr_cnt;
        tb_char  <= BLANK_CHAR;
      end else if (pop) begin
        tb_waddr <= head.addr;
        tb_char  <= head.chr;
      end
`else
      tb_we <= pop;
      if (pop) begin
        tb_waddr <= head.addr;
        tb_char  <= head.chr;
      end
`endif

      if (push) wr_ptr <= wr_ptr + PTR_W'(1);

`ifdef TEXT_CLEAR_EN
      if (clr_req) begin
        // Flush: everything queued before this edge is dropped; an entry
        // pushed on this same edge sits at the old wr_ptr and becomes head.
        rd_ptr     <= wr_ptr;
        fifo_count <= push ? 4'd1 : 4'd0;
        state      <= CLEAR;
        clr_cnt    <= '0;
        clr_busy   <= 1'b1;
      end else
`endif
      begin
        if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
        case ({push, pop})
          2'b10:   fifo_count <= fifo_count + 4'd1;
          2'b01:   fifo_count <= fifo_count - 4'd1;
          default: ;
        endcase

        case (state)
          IDLE: begin
            if (pop) state <= DRAIN;
          end
          DRAIN: begin
            // Leave once the window closes or the last queued entry is gone.
            if (!write_window || fifo_empty ||
                (pop && !push && fifo_count == 4'd1)) begin
              state <= IDLE;
            end
          end
`ifdef TEXT_CLEAR_EN
          CLEAR: begin
            if (blank_write) begin
              if (clr_cnt == LAST_CELL) begin
                state    <= IDLE;
                clr_cnt  <= '0;
                clr_busy <= 1'b0;
              end else begin
                clr_cnt <= clr_cnt + 12'd1;
              end
            end
          end
`endif
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_text_write_scheduler.sv
// -----------------------------------------------------------------------------
// tb_text_write_scheduler
//
// Directed bench for text_write_scheduler. A monitor logs every tb_we pulse
// (address, code, cycle) at the falling edge; each scenario compares that log
// and the status outputs against hand-computed expectations. The clear-engine
// scenarios are built when TEXT_CLEAR_EN is defined; otherwise the bench
// confirms clr_req is ignored.
// -----------------------------------------------------------------------------
module tb_text_write_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req;
  logic [11:0] cpu_addr;
  logic [3:0]  cpu_char;
  logic        cpu_ack;
  logic        clr_req;
  logic        clr_busy;
  logic        write_window;
  logic        tb_we;
  logic [11:0] tb_waddr;
  logic [3:0]  tb_char;
  logic [3:0]  fifo_count;
  logic        fifo_full;

  text_write_scheduler dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cpu_req      (cpu_req),
    .cpu_addr     (cpu_addr),
    .cpu_char     (cpu_char),
    .cpu_ack      (cpu_ack),
    .clr_req      (clr_req),
    .clr_busy     (clr_busy),
    .write_window (write_window),
    .tb_we        (tb_we),
    .tb_waddr     (tb_waddr),
    .tb_char      (tb_char),
    .fifo_count   (fifo_count),
    .fifo_full    (fifo_full)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [11:0] addr;
    logic [3:0]  chr;
    int          cyc;
  } wr_t;

  wr_t wlog[$];

  always @(negedge clk) begin
    if (tb_we) wlog.push_back('{addr: tb_waddr, chr: tb_char, cyc: cyc});
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One accepted CPU write; the ack is checked before the edge that takes it.
  task automatic cpu_write(input logic [11:0] a, input logic [3:0] c, input string tag);
    cpu_req  = 1'b1;
    cpu_addr = a;
    cpu_char = c;
    #1;
    check(tag, cpu_ack, 1'b1);
    step();
    cpu_req = 1'b0;
  endtask

  task automatic open_window(input int n);
    write_window = 1'b1;
    repeat (n) step();
    write_window = 1'b0;
  endtask

  initial begin
    int bad;
    bool_loop: begin end
    rst_n        = 1'b0;
    cpu_req      = 1'b1;
    cpu_addr     = 12'h001;
    cpu_char     = 4'h1;
    clr_req      = 1'b0;
    write_window = 1'b0;

    // ---- reset state --------------------------------------------------------
    repeat (2) @(posedge clk);
    #2;
    check("rst_ack",      cpu_ack,    1'b0);
    check("rst_count",    fifo_count, 4'd0);
    check("rst_we",       tb_we,      1'b0);
    check("rst_waddr",    tb_waddr,   12'd0);
    check("rst_char",     tb_char,    4'd0);
    check("rst_clr_busy", clr_busy,   1'b0);
    cpu_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // ---- 1: queue while blanked off, then drain in order --------------------
    wlog.delete();
    cpu_write(12'h005, 4'h1, "t1_ack0");
    cpu_write(12'h006, 4'h2, "t1_ack1");
    cpu_write(12'h007, 4'h3, "t1_ack2");
    check("t1_count", fifo_count, 4'd3);
    check("t1_no_we", wlog.size(), 0);
    open_window(4);
    check("t1_nwr", wlog.size(), 3);
    if (wlog.size() == 3) begin
      check("t1_a0", {wlog[0].addr, wlog[0].chr}, {12'h005, 4'h1});
      check("t1_a1", {wlog[1].addr, wlog[1].chr}, {12'h006, 4'h2});
      check("t1_a2", {wlog[2].addr, wlog[2].chr}, {12'h007, 4'h3});
      check("t1_consec", wlog[2].cyc - wlog[0].cyc, 2);
    end
    check("t1_empty", fifo_count, 4'd0);

    // ---- 2: fill to 8, ninth held until one pop ------------------------------
    wlog.delete();
    for (int i = 0; i < 8; i++) cpu_write(12'h100 + 12'(i), 4'(i), "t2_ack");
    cpu_req  = 1'b1;
    cpu_addr = 12'h108;
    cpu_char = 4'h8;
    #1;
    check("t2_ninth_ack",  cpu_ack,    1'b0);
    check("t2_full",       fifo_full,  1'b1);
    check("t2_count8",     fifo_count, 4'd8);
    step();
    check("t2_hold_count", fifo_count, 4'd8);
    write_window = 1'b1;           // one pop; ninth still refused at this edge
    #1;
    check("t2_pop_ack", cpu_ack, 1'b0);
    step();
    write_window = 1'b0;
    check("t2_count7", fifo_count, 4'd7);
    #1;
    check("t2_ninth_taken", cpu_ack, 1'b1);
    step();
    cpu_req = 1'b0;
    check("t2_count_back8", fifo_count, 4'd8);
    check("t2_one_write",   wlog.size(), 1);
    open_window(10);
    check("t2_nwr", wlog.size(), 9);
    bad = 0;
    foreach (wlog[i]) if (wlog[i].addr != 12'h100 + 12'(i) || wlog[i].chr != 4'(i)) bad++;
    check("t2_order", bad, 0);

    // ---- 3: off-screen address acked and dropped; last cell kept ------------
    wlog.delete();
    cpu_write(12'd2400, 4'h5, "t3_ack_oob");
    check("t3_count_oob", fifo_count, 4'd0);
    cpu_write(12'd2399, 4'h6, "t3_ack_last");
    check("t3_count_last", fifo_count, 4'd1);
    open_window(4);
    check("t3_nwr", wlog.size(), 1);
    if (wlog.size() == 1) check("t3_entry", {wlog[0].addr, wlog[0].chr}, {12'd2399, 4'h6});

`ifndef TEXT_CLEAR_EN
    // ---- clear engine absent: clr_req changes nothing -----------------------
    wlog.delete();
    cpu_write(12'h010, 4'hA, "nc_ack0");
    cpu_write(12'h011, 4'hB, "nc_ack1");
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    check("nc_count", fifo_count, 4'd2);
    check("nc_busy",  clr_busy,   1'b0);
    open_window(3);
    check("nc_nwr", wlog.size(), 2);
    if (wlog.size() == 2) begin
      check("nc_e0", {wlog[0].addr, wlog[0].chr}, {12'h010, 4'hA});
      check("nc_e1", {wlog[1].addr, wlog[1].chr}, {12'h011, 4'hB});
    end
`else
    // ---- 4: clear flushes queue, keeps same-edge write, fills all cells -----
    wlog.delete();
    cpu_write(12'h010, 4'hA, "t4_ack0");
    cpu_write(12'h011, 4'hB, "t4_ack1");
    write_window = 1'b1;
    clr_req      = 1'b1;
    cpu_req      = 1'b1;
    cpu_addr     = 12'h0AA;
    cpu_char     = 4'h9;
    #1;
    check("t4_same_edge_ack", cpu_ack, 1'b1);
    step();
    clr_req = 1'b0;
    cpu_req = 1'b0;
    check("t4_busy",  clr_busy,   1'b1);
    check("t4_count", fifo_count, 4'd1);
    begin
      int n = 0;
      while (clr_busy && n < 3000) begin
        step();
        n++;
      end
      check("t4_timeout", clr_busy, 1'b0);
    end
    check("t4_last_we",   tb_we,    1'b1);
    check("t4_last_addr", tb_waddr, 12'd2399);
    repeat (3) step();
    write_window = 1'b0;
    check("t4_nwr", wlog.size(), 2401);
    bad = 0;
    for (int i = 0; i < 2400 && i < wlog.size(); i++) begin
      if (wlog[i].addr != 12'(i) || wlog[i].chr != 4'h0) bad++;
      if (i > 0 && wlog[i].cyc != wlog[i-1].cyc + 1) bad++;
    end
    check("t4_fill_seq", bad, 0);
    if (wlog.size() == 2401) check("t4_kept", {wlog[2400].addr, wlog[2400].chr}, {12'h0AA, 4'h9});

    // ---- 5: clear with window 10 on / 10 off, write queued mid-clear --------
    wlog.delete();
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    check("t5_busy", clr_busy, 1'b1);
    begin
      int k = 0;
      int we_bad = 0;
      logic w;
      while (clr_busy && k < 6000) begin
        w = ((k / 10) % 2) == 0;
        write_window = w;
        if (k == 100) begin
          cpu_req  = 1'b1;
          cpu_addr = 12'h123;
          cpu_char = 4'h7;
          #1;
          check("t5_mid_ack", cpu_ack, 1'b1);
        end
        step();
        cpu_req = 1'b0;
        if (tb_we !== w) we_bad++;
        k++;
      end
      check("t5_timeout", clr_busy, 1'b0);
      check("t5_we_follows_window", we_bad, 0);
    end
    check("t5_count_queued", fifo_count, 4'd1);
    open_window(3);
    check("t5_nwr", wlog.size(), 2401);
    bad = 0;
    for (int i = 0; i < 2400 && i < wlog.size(); i++)
      if (wlog[i].addr != 12'(i) || wlog[i].chr != 4'h0) bad++;
    check("t5_fill_seq", bad, 0);
    if (wlog.size() == 2401) check("t5_after", {wlog[2400].addr, wlog[2400].chr}, {12'h123, 4'h7});
`endif

    // ---- 6: reset in the middle of a drain ----------------------------------
    wlog.delete();
    for (int i = 0; i < 4; i++) cpu_write(12'h020 + 12'(i), 4'(i + 1), "t6_ack");
    write_window = 1'b1;
    step();
    check("t6_draining", tb_we, 1'b1);
    #1;
    rst_n   = 1'b0;
    cpu_req = 1'b1;
    #1;
    check("t6_we0",    tb_we,      1'b0);
    check("t6_waddr0", tb_waddr,   12'd0);
    check("t6_char0",  tb_char,    4'd0);
    check("t6_count0", fifo_count, 4'd0);
    check("t6_ack0",   cpu_ack,    1'b0);
    cpu_req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) step();
    write_window = 1'b0;
    check("t6_count_after", fifo_count, 4'd0);
    check("t6_no_stale",    wlog.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
